// File: rtl/sprite_pkg.sv
// Shared types and constants for the per-scanline sprite scheduler.
package sprite_pkg;

    localparam int H_ACTIVE    = 640;
    localparam int H_TOTAL     = 800;
    localparam int V_ACTIVE    = 480;
    localparam int V_TOTAL     = 525;
    localparam int NUM_ENTRIES = 20;
    localparam int ENTRY_W     = 24;

    // One sprite table entry as packed in gl_input: [23] enable, [22:19] shape, [18:9] x, [8:0] y.
    typedef struct packed {
        logic       enable;
        logic [3:0] shape;
        logic [9:0] x;
        logic [8:0] y;
    } sprite_entry_t;

    // One published slot for the pixel datapath.
    typedef struct packed {
        logic       valid;
        logic [9:0] x;
        logic [3:0] shape;
        logic [4:0] row;
    } slot_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

    // Line evaluated during the blank of line v: the following line, wrapping at frame end.
    function automatic logic [9:0] next_line(input logic [9:0] v);
        return (v == 10'(V_TOTAL - 1)) ? 10'd0 : (v + 10'd1);
    endfunction

endpackage

// File: rtl/sprite_hit_check.sv
// Combinational test of one table entry against the target line.
module sprite_hit_check
    import sprite_pkg::*;
#(
    parameter int SPRITE_H = 32
) (
    input  sprite_entry_t entry,
    input  logic [9:0]    target,
    output logic          hit,
    output logic [4:0]    row
);

    logic [9:0] y_s;
    logic [9:0] y_end_s;

    // y is 9 bits, so y + SPRITE_H always fits in 10 bits and never wraps.
    assign y_s     = {1'b0, entry.y};
    assign y_end_s = y_s + 10'(SPRITE_H);
    assign hit     = entry.enable && (target >= y_s) && (target < y_end_s);
    // Row only matters on a hit, where t - y < 32, so the low 5 bits suffice.
    assign row     = target[4:0] - y_s[4:0];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite evaluator: scans the frame-latched table during hblank
// and publishes up to NSLOTS sprites for the next line at the end of the line.
module sprite_line_scheduler
    import sprite_pkg::*;
#(
    parameter int NUM_ENTRIES = 20,
    parameter int NSLOTS      = 4,
    parameter int SPRITE_H    = 32,
    parameter int EVAL_START  = 640
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [511:0]         gl_input,
    input  logic                 write,
    input  logic [9:0]           VGA_HCOUNT,
    input  logic [9:0]           VGA_VCOUNT,
    output logic [NSLOTS-1:0]    slot_valid,
    output logic [NSLOTS*10-1:0] slot_x,
    output logic [NSLOTS*4-1:0]  slot_shape,
    output logic [NSLOTS*5-1:0]  slot_row,
    output logic                 overflow,
    output logic                 busy
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int TBL_W = NUM_ENTRIES * ENTRY_W;

    scan_state_t                       state_q, state_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [9:0]                        t_q, t_d;
    logic [9:0]                        hcount_q, hcount_d;
    sprite_entry_t [NUM_ENTRIES-1:0]   pending_q, pending_d;
    sprite_entry_t [NUM_ENTRIES-1:0]   active_q, active_d;
    slot_t [NSLOTS-1:0]                next_q, next_d;
    logic                              next_ovf_q, next_ovf_d;
    slot_t [NSLOTS-1:0]                out_q, out_d;
    logic                              ovf_q, ovf_d;
    logic                              busy_q, busy_d;

    logic [9:0]    t_s;
    logic          vblank_s;
    logic          trig_s;
    logic          commit_s;
    sprite_entry_t cur_s;
    logic          hit_s;
    logic [4:0]    row_s;
    slot_t         new_slot_s;
    logic          found_s;
    logic          take_s;
    logic          unused_s;

    // Upper gl_input bits carry no table data.
    assign unused_s = ^gl_input[511:TBL_W];

    assign t_s      = next_line(VGA_VCOUNT);
    assign vblank_s = (VGA_VCOUNT == 10'(V_ACTIVE)) && (VGA_HCOUNT == 10'd0) && (hcount_q != 10'd0);
    assign trig_s   = (VGA_HCOUNT == 10'(EVAL_START)) && (hcount_q != 10'(EVAL_START));
    assign commit_s = (VGA_HCOUNT == 10'(H_TOTAL - 1)) && (hcount_q != 10'(H_TOTAL - 1));
    assign cur_s    = active_q[idx_q];

    sprite_hit_check #(
        .SPRITE_H (SPRITE_H)
    ) u_hit (
        .entry  (cur_s),
        .target (t_q),
        .hit    (hit_s),
        .row    (row_s)
    );

    // Next-state logic: table shadowing, scan FSM, slot fill and end-of-line commit.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        t_d        = t_q;
        hcount_d   = VGA_HCOUNT;
        pending_d  = pending_q;
        active_d   = active_q;
        next_d     = next_q;
        next_ovf_d = next_ovf_q;
        out_d      = out_q;
        ovf_d      = ovf_q;
        found_s    = 1'b0;
        take_s     = 1'b0;

        new_slot_s.valid = 1'b1;
        new_slot_s.x     = cur_s.x;
        new_slot_s.shape = cur_s.shape;
        new_slot_s.row   = row_s;

        if (write) begin
            pending_d = gl_input[TBL_W-1:0];
        end else begin
            pending_d = pending_q;
        end

        // A write on the transfer cycle bypasses pending so it lands this frame.
        if (vblank_s) begin
            active_d = write ? gl_input[TBL_W-1:0] : pending_q;
        end else begin
            active_d = active_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (trig_s && (t_s < 10'(V_ACTIVE))) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    t_d     = t_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                for (int s = 0; s < NSLOTS; s++) begin
                    take_s    = hit_s && !found_s && !next_q[s].valid;
                    next_d[s] = take_s ? new_slot_s : next_q[s];
                    found_s   = found_s | take_s;
                end
                next_ovf_d = next_ovf_q | (hit_s & ~found_s);
                if (idx_q == IDX_W'(NUM_ENTRIES - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (commit_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Commit every line, so blank lines publish the empty set.
        if (commit_s) begin
            out_d      = next_q;
            ovf_d      = next_ovf_q;
            next_d     = '0;
            next_ovf_d = 1'b0;
        end else begin
            out_d = out_q;
            ovf_d = ovf_q;
        end

        busy_d = (state_d == ST_SCAN);
    end

    // State registers with synchronous reset; reset discards any partial scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            t_q        <= 10'd0;
            hcount_q   <= 10'd0;
            pending_q  <= '0;
            active_q   <= '0;
            next_q     <= '0;
            next_ovf_q <= 1'b0;
            out_q      <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            t_q        <= t_d;
            hcount_q   <= hcount_d;
            pending_q  <= pending_d;
            active_q   <= active_d;
            next_q     <= next_d;
            next_ovf_q <= next_ovf_d;
            out_q      <= out_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
        end
    end

    // Unpack the registered slot set onto the flat output buses.
    always_comb begin
        for (int i = 0; i < NSLOTS; i++) begin
            slot_valid[i]        = out_q[i].valid;
            slot_x[i*10 +: 10]   = out_q[i].x;
            slot_shape[i*4 +: 4] = out_q[i].shape;
            slot_row[i*5 +: 5]   = out_q[i].row;
        end
        overflow = ovf_q;
        busy     = busy_q;
    end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed testbench for sprite_line_scheduler.
module tb_sprite_line_scheduler;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [511:0] gl_input = '0;
    logic         wr = 1'b0;
    logic [9:0]   hcount = 10'd0;
    logic [9:0]   vcount = 10'd0;
    logic [3:0]   slot_valid;
    logic [39:0]  slot_x;
    logic [15:0]  slot_shape;
    logic [19:0]  slot_row;
    logic         overflow;
    logic         busy;

    int checks = 0;
    int errors = 0;
    logic busy_at_scan;
    logic busy_after;

    sprite_line_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .gl_input   (gl_input),
        .write      (wr),
        .VGA_HCOUNT (hcount),
        .VGA_VCOUNT (vcount),
        .slot_valid (slot_valid),
        .slot_x     (slot_x),
        .slot_shape (slot_shape),
        .slot_row   (slot_row),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] ent(input logic en, input logic [3:0] sh,
                                        input logic [9:0] x, input logic [8:0] y);
        return {en, sh, x, y};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Capture a table into pending.
    task automatic load(input logic [511:0] tbl);
        hcount   = 10'd1;
        gl_input = tbl;
        wr       = 1'b1;
        tick();
        wr       = 1'b0;
    endtask

    // Run the interesting parts of line v; afterwards outputs describe line v+1.
    task automatic run_line(input logic [9:0] v, input logic wr0);
        vcount = v;
        hcount = 10'd0;
        wr     = wr0;
        tick();
        wr     = 1'b0;
        hcount = 10'd640;
        tick();
        busy_at_scan = busy;
        hcount = 10'd641;
        repeat (22) tick();
        busy_after = busy;
        hcount = 10'd799;
        tick();
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        repeat (2) tick();
        reset  = 1'b0;
        tick();
        checks++;
        if ({slot_valid, slot_x, slot_shape, slot_row, overflow, busy} !== 82'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h expected 0", {slot_valid, slot_x, slot_shape, slot_row, overflow, busy});
        end
    endtask

    task automatic test_single();
        logic [511:0] tbl;
        tbl = '0;
        tbl[23:0] = ent(1'b1, 4'd3, 10'd100, 9'd50);
        load(tbl);
        run_line(10'd480, 1'b0);
        for (int l = 49; l <= 82; l++) begin
            run_line(10'(l - 1), 1'b0);
            checks++;
            if (l >= 50 && l <= 81) begin
                if (slot_valid !== 4'b0001 || slot_x[9:0] !== 10'd100 || slot_shape[3:0] !== 4'd3 ||
                    slot_row[4:0] !== 5'(l - 50) || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL single_line%0d got v=%b x=%0d sh=%0d row=%0d ovf=%b expected v=0001 x=100 sh=3 row=%0d ovf=0",
                             l, slot_valid, slot_x[9:0], slot_shape[3:0], slot_row[4:0], overflow, l - 50);
                end
            end else begin
                if (slot_valid !== 4'b0000) begin
                    errors++;
                    $display("FAIL single_edge_line%0d got valid=%b expected 0000", l, slot_valid);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [511:0] tbl;
        tbl = '0;
        for (int i = 0; i < 6; i++) tbl[i*24 +: 24] = ent(1'b1, 4'(i + 1), 10'(10 * i + 10), 9'd200);
        load(tbl);
        run_line(10'd480, 1'b0);
        run_line(10'd199, 1'b0);
        checks++;
        if (slot_valid !== 4'b1111 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_line200 got valid=%b ovf=%b expected 1111 1", slot_valid, overflow);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (slot_x[i*10 +: 10] !== 10'(10 * i + 10) || slot_shape[i*4 +: 4] !== 4'(i + 1) ||
                slot_row[i*5 +: 5] !== 5'd0) begin
                errors++;
                $display("FAIL ovf_slot%0d got x=%0d sh=%0d row=%0d expected x=%0d sh=%0d row=0",
                         i, slot_x[i*10 +: 10], slot_shape[i*4 +: 4], slot_row[i*5 +: 5], 10 * i + 10, i + 1);
            end
        end
        checks++;
        if (busy_at_scan !== 1'b1 || busy_after !== 1'b0) begin
            errors++;
            $display("FAIL busy got scan=%b after=%b expected 1 0", busy_at_scan, busy_after);
        end
        run_line(10'd231, 1'b0);
        checks++;
        if (slot_valid !== 4'b0000 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_line232 got valid=%b ovf=%b expected 0000 0", slot_valid, overflow);
        end
    endtask

    task automatic test_shadow();
        logic [511:0] tbl;
        tbl = '0;
        tbl[23:0] = ent(1'b1, 4'd5, 10'd300, 9'd10);
        vcount = 10'd100;
        load(tbl);
        run_line(10'd199, 1'b0);
        checks++;
        if (slot_valid !== 4'b1111 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL shadow_old_line200 got valid=%b ovf=%b expected 1111 1", slot_valid, overflow);
        end
        run_line(10'd10, 1'b0);
        checks++;
        if (slot_valid !== 4'b0000) begin
            errors++;
            $display("FAIL shadow_early_line11 got valid=%b expected 0000", slot_valid);
        end
        run_line(10'd480, 1'b0);
        run_line(10'd9, 1'b0);
        checks++;
        if (slot_valid !== 4'b0001 || slot_x[9:0] !== 10'd300 || slot_shape[3:0] !== 4'd5 || slot_row[4:0] !== 5'd0) begin
            errors++;
            $display("FAIL shadow_new_line10 got v=%b x=%0d sh=%0d row=%0d expected 0001 300 5 0",
                     slot_valid, slot_x[9:0], slot_shape[3:0], slot_row[4:0]);
        end
    endtask

    task automatic test_vblank_write();
        logic [511:0] tbl;
        tbl = '0;
        tbl[23:0] = ent(1'b1, 4'd2, 10'd50, 9'd300);
        load(tbl);
        tbl[23:0] = ent(1'b1, 4'd7, 10'd60, 9'd320);
        gl_input = tbl;
        run_line(10'd480, 1'b1);
        run_line(10'd299, 1'b0);
        checks++;
        if (slot_valid !== 4'b0000) begin
            errors++;
            $display("FAIL vbwrite_line300 got valid=%b expected 0000", slot_valid);
        end
        run_line(10'd319, 1'b0);
        checks++;
        if (slot_valid !== 4'b0001 || slot_x[9:0] !== 10'd60 || slot_shape[3:0] !== 4'd7 || slot_row[4:0] !== 5'd0) begin
            errors++;
            $display("FAIL vbwrite_line320 got v=%b x=%0d sh=%0d row=%0d expected 0001 60 7 0",
                     slot_valid, slot_x[9:0], slot_shape[3:0], slot_row[4:0]);
        end
    endtask

    task automatic test_wrap();
        logic [511:0] tbl;
        logic [9:0]   lines [5];
        logic [3:0]   ev [5];
        logic [9:0]   ex [5];
        logic [4:0]   er [5];
        tbl = '0;
        tbl[23:0]  = ent(1'b1, 4'd1, 10'd5, 9'd0);
        tbl[47:24] = ent(1'b1, 4'd9, 10'd600, 9'd470);
        load(tbl);
        run_line(10'd480, 1'b0);
        lines = '{10'd524, 10'd20, 10'd469, 10'd478, 10'd479};
        ev    = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        ex    = '{10'd5, 10'd5, 10'd600, 10'd600, 10'd0};
        er    = '{5'd0, 5'd21, 5'd0, 5'd9, 5'd0};
        for (int k = 0; k < 5; k++) begin
            run_line(lines[k], 1'b0);
            checks++;
            if (slot_valid !== ev[k] || (ev[k] != 4'b0000 && (slot_x[9:0] !== ex[k] || slot_row[4:0] !== er[k]))) begin
                errors++;
                $display("FAIL wrap_after_line%0d got v=%b x=%0d row=%0d expected v=%b x=%0d row=%0d",
                         lines[k], slot_valid, slot_x[9:0], slot_row[4:0], ev[k], ex[k], er[k]);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [511:0] tbl;
        tbl = '0;
        tbl[23:0] = ent(1'b1, 4'd3, 10'd100, 9'd50);
        load(tbl);
        run_line(10'd480, 1'b0);
        run_line(10'd59, 1'b0);
        checks++;
        if (slot_valid !== 4'b0001 || slot_row[4:0] !== 5'd10) begin
            errors++;
            $display("FAIL rst_pre_line60 got v=%b row=%0d expected 0001 10", slot_valid, slot_row[4:0]);
        end
        vcount = 10'd60;
        hcount = 10'd0;
        tick();
        hcount = 10'd640;
        tick();
        hcount = 10'd641;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({slot_valid, slot_x, slot_shape, slot_row, overflow, busy} !== 82'd0) begin
            errors++;
            $display("FAIL rst_mid_scan got %h expected 0", {slot_valid, slot_x, slot_shape, slot_row, overflow, busy});
        end
        hcount = 10'd799;
        tick();
        checks++;
        if (slot_valid !== 4'b0000 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_partial got v=%b ovf=%b expected 0000 0", slot_valid, overflow);
        end
        load(tbl);
        run_line(10'd480, 1'b0);
        run_line(10'd60, 1'b0);
        checks++;
        if (slot_valid !== 4'b0001 || slot_x[9:0] !== 10'd100 || slot_shape[3:0] !== 4'd3 || slot_row[4:0] !== 5'd11) begin
            errors++;
            $display("FAIL rst_recover_line61 got v=%b x=%0d sh=%0d row=%0d expected 0001 100 3 11",
                     slot_valid, slot_x[9:0], slot_shape[3:0], slot_row[4:0]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_shadow();
        test_vblank_write();
        test_wrap();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_line_scheduler.md
# sprite_line_scheduler

Per-scanline sprite evaluator between the 20-entry sprite table, the VGA timing counters and the sprite pixel datapath. During each horizontal blank it scans the frame-latched table and selects up to NSLOTS sprites that intersect the next visible line. It publishes their x position, shape id and row offset as double-buffered slot registers, so the pixel datapath's ROM lookups only see sprites live on the current line. Table updates are shadowed and take effect only at vertical blank, giving tear-free frames.

## Interface
- NUM_ENTRIES, 20: sprite table entries.
- NSLOTS, 4: sprites displayable per line.
- SPRITE_H, 32: sprite height in lines (power of two, ≤ 32).
- EVAL_START, 640: hcount on which evaluation begins.
- clk  in  1  system clock; counters may advance on any subset of cycles.
- reset  in  1  synchronous, active-high.
- gl_input  in  512  packed table; entry i at [24i+23:24i], bits 511:480 ignored.
- write  in  1  capture gl_input into the pending table this cycle.
- VGA_HCOUNT  in  10  current pixel column, 0..799.
- VGA_VCOUNT  in  10  current line, 0..524.
- slot_valid  out  NSLOTS  slot holds a sprite for the current line.
- slot_x  out  NSLOTS×10  sprite left x.
- slot_shape  out  NSLOTS×4  shape/ROM id.
- slot_row  out  NSLOTS×5  row within sprite (current line − y).
- overflow  out  1  more than NSLOTS hits on the current line.
- busy  out  1  scan in progress.

## Operation
- Entry format: [23] enable, [22:19] shape, [18:9] x, [8:0] y.
- Table registers:
  - pending captures gl_input on write.
  - active ← pending on the first cycle of VGA_VCOUNT==480 && VGA_HCOUNT==0. If write is high that same cycle, active ← gl_input directly.
- Edge detect: a registered copy of VGA_HCOUNT defines "first cycle" of a count value; every trigger fires once per count value.
- Target line t = VGA_VCOUNT+1, or 0 when VGA_VCOUNT==524.
- FSM:
  - IDLE → SCAN on the first cycle of VGA_HCOUNT==EVAL_START with t<480. If t≥480, stay IDLE and the next set is left empty.
  - SCAN: examines entry idx (0..NUM_ENTRIES−1), one per cycle.
    - Hit when enable && t ≥ y && t < y+SPRITE_H, computed in 10 bits with no wrap.
    - A hit fills the lowest free next-slot; lower index has priority.
    - A hit with all slots full sets next_overflow.
    - After idx NUM_ENTRIES−1 → DONE.
  - DONE → IDLE when commit fires.
- Commit: first cycle of VGA_HCOUNT==799.
  - Next-slot set and next_overflow copy to the outputs.
  - Next-slot set and next_overflow then clear.
  - Commit happens every line, including blank lines, so lines ≥480 publish empty slots.
- busy is high exactly in SCAN.

## Timing
- Reset: all outputs 0, FSM IDLE, pending/active/next sets 0.
- Reset mid-scan aborts; no partial result is ever committed.
- Scan latency: NUM_ENTRIES cycles from the trigger cycle, registered; must complete before hcount 799 at ≥ 1 clk per pixel.
- Slot outputs change only on commit cycles and are stable for the whole line.
- A write during SCAN affects only pending, never the current scan.
- slot_row = t − y, 5 bits.

## Structure
- sprite_pkg holds:
  - typedef struct packed sprite_entry_t {enable, shape, x, y};
  - typedef slot_t;
  - constants H_ACTIVE=640, H_TOTAL=800, V_ACTIVE=480, V_TOTAL=525, NUM_ENTRIES.
- Sub-module sprite_hit_check (combinational): entry + t → hit, row.
- FSM, table registers and slot buffers stay in the top block.

## Test plan
- Entry 0 = {1, shape 3, x 100, y 50}; committed lines 50..81 show slot0 valid, x=100, shape=3, row 0..31; lines 49 and 82 show slot_valid=0.
- Entries 0..5 all enabled, y=200: on line 200, slots hold entries 0..3 in order and overflow=1; on line 232, overflow=0.
- Write a new table with y=10 at VCOUNT=100: no change on lines 101..479; the new sprite appears on line 10 of the next frame.
- write asserted on the exact vblank transfer cycle: the new gl_input is active for the next frame.
- Line 524 evaluates t=0: entry y=0 appears on line 0; entry y=470 (SPRITE_H=32) is visible on lines 470..479 only and never on lines 0..21.
- Assert reset at scan cycle 7 of line 60: all outputs 0 next cycle; the next full scan commits normally on the following line.
